// File: rtl/board_uart_formatter.sv
// Streams a registered snapshot of the Life board to a UART transmitter as an ANSI
// frame (home sequence, cells row by row, CR+LF between rows). Define BOARD_FMT_CLEAR_EN to prepend ESC[2J.
module board_uart_formatter #(
  parameter int         WIDTH      = 8,
  parameter int         HEIGHT     = 8,
  parameter logic [7:0] ALIVE_CHAR = 8'h4F,
  parameter logic [7:0] DEAD_CHAR  = 8'h20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH*HEIGHT-1:0]   board,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int IW = $clog2(WIDTH * HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

`ifdef BOARD_FMT_CLEAR_EN
  localparam int PFX_W = 3;
`else
  localparam int PFX_W = 2;
`endif
  // The prefix length is a power of two, so its last index is all ones.
  localparam logic [PFX_W-1:0] PFX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFIX,
    S_CELL,
    S_CR,
    S_LF,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [PFX_W-1:0]          pfx_q, pfx_d;
  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      tx_valid_q, tx_valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      load_snap;
  logic [WIDTH*HEIGHT-1:0]   snap_q;
  logic                      xfer;

  function automatic logic [7:0] prefix_byte(input logic [PFX_W-1:0] idx);
`ifdef BOARD_FMT_CLEAR_EN
    case (idx)
      3'd0:    return 8'h1B;
      3'd1:    return 8'h5B;
      3'd2:    return 8'h32;
      3'd3:    return 8'h4A;
      3'd4:    return 8'h1B;
      3'd5:    return 8'h5B;
      3'd6:    return 8'h3B;
      default: return 8'h48;
    endcase
`else
    case (idx)
      2'd0:    return 8'h1B;
      2'd1:    return 8'h5B;
      2'd2:    return 8'h3B;
      default: return 8'h48;
    endcase
`endif
  endfunction

  function automatic logic [7:0] cell_byte(input logic [WIDTH*HEIGHT-1:0] cells,
                                           input logic [CW-1:0] c,
                                           input logic [RW-1:0] r);
    logic [IW-1:0] idx;
    idx = IW'(int'(r) * WIDTH + int'(c));
    return cells[idx] ? ALIVE_CHAR : DEAD_CHAR;
  endfunction

  assign xfer = tx_valid_q & tx_ready;

  // NOTE: every variable gets a default before the case; a path that skips an assignment would infer a latch.
  always_comb begin
    state_d    = state_q;
    pfx_d      = pfx_q;
    col_d      = col_q;
    row_d      = row_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_snap  = 1'b0;

    case (state_q)
      // DONE behaves like IDLE so a start coinciding with the done pulse is taken.
      S_IDLE, S_DONE: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        if (start) begin
          load_snap  = 1'b1;
          state_d    = S_PREFIX;
          pfx_d      = '0;
          col_d      = '0;
          row_d      = '0;
          tx_data_d  = prefix_byte('0);
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_PREFIX: if (xfer) begin
        if (pfx_q == PFX_LAST) begin
          state_d   = S_CELL;
          pfx_d     = '0;
          tx_data_d = cell_byte(snap_q, '0, '0);
        end else begin
          pfx_d     = pfx_q + 1'b1;
          tx_data_d = prefix_byte(pfx_q + 1'b1);
        end
      end
      S_CELL: if (xfer) begin
        if (col_q != COL_LAST) begin
          col_d     = col_q + 1'b1;
          tx_data_d = cell_byte(snap_q, col_q + 1'b1, row_q);
        end else if (row_q != ROW_LAST) begin
          state_d   = S_CR;
          tx_data_d = 8'h0D;
        end else begin
          state_d    = S_DONE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
      S_CR: if (xfer) begin
        state_d   = S_LF;
        tx_data_d = 8'h0A;
      end
      S_LF: if (xfer) begin
        state_d   = S_CELL;
        col_d     = '0;
        row_d     = row_q + 1'b1;
        tx_data_d = cell_byte(snap_q, '0, row_q + 1'b1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pfx_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pfx_q      <= pfx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // NOTE: the snapshot is pure data that is always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_snap) snap_q <= board;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_board_uart_formatter.sv
// Scoreboard bench for board_uart_formatter: expected frames are queued at start and popped on each handshake.
module tb_board_uart_formatter;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;
`ifdef BOARD_FMT_CLEAR_EN
  localparam int PFX_LEN = 8;
`else
  localparam int PFX_LEN = 4;
`endif
  localparam int LEN = PFX_LEN + N + 2 * (H - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] board = '0;
  logic         busy;
  logic         done;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  bit           rand_mode = 1'b0;

  logic [7:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int nbytes, nvalid, nbusy, ndone;
  bit         stalled = 1'b0;
  logic [7:0] held = 8'h00;

  board_uart_formatter #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .board    (board),
    .busy     (busy),
    .done     (done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic void push_frame(input logic [N-1:0] b);
`ifdef BOARD_FMT_CLEAR_EN
    exp_q.push_back(8'h1B); exp_q.push_back(8'h5B);
    exp_q.push_back(8'h32); exp_q.push_back(8'h4A);
`endif
    exp_q.push_back(8'h1B); exp_q.push_back(8'h5B);
    exp_q.push_back(8'h3B); exp_q.push_back(8'h48);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) exp_q.push_back(b[y*W+x] ? 8'h4F : 8'h20);
      if (y < H - 1) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
  endfunction

  // Monitor: samples on the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) nbusy++;
      if (tx_valid) nvalid++;
      if (done) ndone++;
      if (stalled) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== held)
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, held);
        else passes++;
      end
      if (tx_valid && tx_ready) begin
        nbytes++;
        checks++;
        if (exp_q.size() == 0)
          $display("FAIL unexpected_byte: got %h with no byte outstanding", tx_data);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e)
            $display("FAIL byte_%0d: got %h, required %h", nbytes, tx_data, e);
          else passes++;
        end
      end
      stalled = tx_valid && !tx_ready;
      held    = tx_data;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts;
    nbytes = 0; nvalid = 0; nbusy = 0; ndone = 0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int cyc = 0;
    while (ndone < target && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (ndone < target) $display("FAIL %s_timeout: done count %0d, required %0d", name, ndone, target);
    else passes++;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) $display("FAIL %s: got %0d, required %0d", name, got, req);
    else passes++;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL %s: busy=%b done=%b valid=%b data=%h, required 0 0 0 00",
               name, busy, done, tx_valid, tx_data);
    else passes++;
  endtask

  task automatic run_frame(input logic [N-1:0] b, input bit strict, input string name);
    tick;
    clear_counts;
    board = b;
    push_frame(b);
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(1, LEN * 8, name);
    repeat (4) tick;
    check_int({name, "_left"}, exp_q.size(), 0);
    check_int({name, "_bytes"}, nbytes, LEN);
    check_int({name, "_dones"}, ndone, 1);
    if (strict) begin
      check_int({name, "_valid_cycles"}, nvalid, LEN);
      check_int({name, "_busy_cycles"}, nbusy, LEN);
    end else begin
      check_int({name, "_busy_vs_valid"}, nbusy, nvalid);
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    check_reset_outputs("reset_values");
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_blank_frame;
    run_frame('0, 1'b1, "blank");
  endtask

  task automatic test_corner_cells;
    logic [N-1:0] b;
    b = '0;
    b[0]   = 1'b1;
    b[N-1] = 1'b1;
    run_frame(b, 1'b1, "corners");
  endtask

  task automatic test_backpressure;
    rand_mode = 1'b1;
    run_frame({$urandom, $urandom}, 1'b0, "backpressure");
    rand_mode = 1'b0;
  endtask

  task automatic test_start_ignored;
    logic [N-1:0] b;
    b = {$urandom, $urandom};
    tick;
    clear_counts;
    board = b;
    push_frame(b);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    board = ~b;
    wait_done(1, LEN * 8, "ignore");
    repeat (30) tick;
    check_int("ignore_left", exp_q.size(), 0);
    check_int("ignore_bytes", nbytes, LEN);
    check_int("ignore_dones", ndone, 1);
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    int cyc = 0;
    tick;
    clear_counts;
    board = {$urandom, $urandom};
    push_frame(board);
    start = 1'b1;
    tick;
    start = 1'b0;
    while (nbytes < 30 && cyc < LEN * 4) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_int("midreset_reach_byte", (nbytes >= 30) ? 1 : 0, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset_values");
    exp_q.delete();
    ndone = 0;
    repeat (10) tick;
    check_int("midreset_no_done", ndone, 0);
    check_int("midreset_idle", int'(busy | tx_valid), 0);
    run_frame({$urandom, $urandom}, 1'b1, "after_reset");
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    tick;
    clear_counts;
    board = {$urandom, $urandom};
    push_frame(board);
    push_frame(board);
    start = 1'b1;
    tick;
    while (ndone < 1 && cyc < LEN * 4) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    tick;
    start = 1'b0;
    wait_done(2, LEN * 8, "b2b");
    repeat (4) tick;
    check_int("b2b_left", exp_q.size(), 0);
    check_int("b2b_bytes", nbytes, 2 * LEN);
    check_int("b2b_dones", ndone, 2);
    check_int("b2b_busy_cycles", nbusy, 2 * LEN);
    exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_blank_frame;
    test_corner_cells;
    test_backpressure;
    test_start_ignored;
    test_reset_mid_frame;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
